// File: rtl/freq_synth_seq.sv
// -----------------------------------------------------------------------------
// freq_synth_seq
//
// Programmable square-wave generator with a 4-slot frequency sequencer.
// Four target frequencies (in Hz) live in a small register memory. While
// running, the sequencer dwells DWELL_CYCLES clocks on each slot in turn.
// A fractional toggle accumulator produces the waveform, so the average
// output frequency matches the stored value exactly, even when the period
// is not a whole number of clocks.
//
// Optional build macro:
//   FREQ_SYNTH_LOOP_EN - when defined, the sequencer wraps from slot 3 back
//                        to slot 0 and keeps running until stop. done never
//                        asserts. When undefined, one pass is made, ending
//                        with a done pulse and a return to idle.
//
// Ports:
//   clk       in   1       system clock, rising edge
//   reset_n   in   1       synchronous active-low reset
//   we        in   1       frequency memory write strobe
//   addr_w    in   2       memory write address
//   data_w    in   FREQ_W  frequency to store in Hz (saturates at CLK_FREQ/2)
//   addr_r    in   2       memory read address
//   data_r    out  FREQ_W  combinational read of mem[addr_r]
//   start     in   1       one-cycle pulse, begins a sequence from idle
//   stop      in   1       one-cycle pulse, aborts a sequence (wins over start)
//   waveform  out  1       generated square wave, registered
//   busy      out  1       high while the sequencer is running
//   slot      out  2       index of the active slot
//   done      out  1       one-cycle pulse when a single pass completes
// -----------------------------------------------------------------------------
module freq_synth_seq #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int FREQ_W       = $clog2(CLK_FREQ / 2),
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [1:0]        addr_w,
  input  logic [FREQ_W-1:0] data_w,
  input  logic [1:0]        addr_r,
  output logic [FREQ_W-1:0] data_r,
  input  logic              start,
  input  logic              stop,
  output logic              waveform,
  output logic              busy,
  output logic [1:0]        slot,
  output logic              done
);

  localparam int ACC_W   = FREQ_W + 2;
  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

  localparam logic [FREQ_W-1:0]  F_MAX      = FREQ_W'(CLK_FREQ / 2);
  localparam logic [ACC_W-1:0]   CLK_ACC    = ACC_W'(CLK_FREQ);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [FREQ_W-1:0]  mem [4];
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [DWELL_W-1:0] dwell;
  logic [FREQ_W-1:0]  cur_freq;

  // Frequency memory. Writes are accepted in any state; values above the
  // Nyquist limit are clamped so the accumulator never needs two toggles
  // in one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr_w] <= (data_w > F_MAX) ? F_MAX : data_w;
    end
  end

  assign data_r   = mem[addr_r];
  assign cur_freq = mem[slot];

  // Adding 2f per clock and wrapping at CLK_FREQ gives 2f toggles per
  // second on average, i.e. an output frequency of exactly f.
  assign acc_sum = acc + {1'b0, cur_freq, 1'b0};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      acc      <= '0;
      waveform <= 1'b0;
      busy     <= 1'b0;
      slot     <= 2'd0;
      done     <= 1'b0;
      dwell    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          acc      <= '0;
          waveform <= 1'b0;
          if (start && !stop) begin
            state <= RUN;
            slot  <= 2'd0;
            dwell <= '0;
            busy  <= 1'b1;
          end
        end

        RUN: begin
          if (stop) begin
            // slot keeps its last value so software can see where it stopped
            state    <= IDLE;
            busy     <= 1'b0;
            waveform <= 1'b0;
            acc      <= '0;
          end else if (dwell == DWELL_LAST) begin
            // Slot boundary: the toggle is skipped this cycle and the level
            // is held, so no runt pulse appears at a frequency change.
            dwell <= '0;
            acc   <= '0;
            if (slot != 2'd3) begin
              slot <= slot + 2'd1;
            end else begin
`ifdef FREQ_SYNTH_LOOP_EN
              slot <= 2'd0;
`else
              state    <= IDLE;
              busy     <= 1'b0;
              waveform <= 1'b0;
              done     <= 1'b1;
`endif
            end
          end else begin
            dwell <= dwell + DWELL_W'(1);
            if (cur_freq != '0) begin
              if (acc_sum >= CLK_ACC) begin
                acc      <= acc_sum - CLK_ACC;
                waveform <= ~waveform;
              end else begin
                acc <= acc_sum;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_synth_seq.sv
// -----------------------------------------------------------------------------
// tb_freq_synth_seq
//
// Directed bench for freq_synth_seq with a shortened dwell. A behavioural
// model predicts every output each cycle: the waveform level within a slot
// is the starting level XOR the parity of floor(sum_of_2f / CLK_FREQ), where
// sum_of_2f accumulates the stored frequency over the slot's active cycles.
// Hand-computed toggle counts and periods pin that model down.
// -----------------------------------------------------------------------------
module tb_freq_synth_seq;

  localparam int CLK_FREQ = 100_000_000;
  localparam int FREQ_W   = $clog2(CLK_FREQ / 2);
  localparam int DWELL    = 4000;
  localparam longint HALF = CLK_FREQ / 2;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              we = 1'b0;
  logic [1:0]        addr_w = '0;
  logic [FREQ_W-1:0] data_w = '0;
  logic [1:0]        addr_r = '0;
  logic [FREQ_W-1:0] data_r;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              waveform;
  logic              busy;
  logic [1:0]        slot;
  logic              done;

  always #5 clk = ~clk;

  freq_synth_seq #(
    .CLK_FREQ    (CLK_FREQ),
    .FREQ_W      (FREQ_W),
    .DWELL_CYCLES(DWELL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .addr_w  (addr_w),
    .data_w  (data_w),
    .addr_r  (addr_r),
    .data_r  (data_r),
    .start   (start),
    .stop    (stop),
    .waveform(waveform),
    .busy    (busy),
    .slot    (slot),
    .done    (done)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_mem [4];
  bit     m_run;
  int     m_slot;
  int     m_dwell;
  longint m_sum;
  bit     m_base;
  bit     m_done;

  function automatic bit m_level();
    return m_base ^ bit'((m_sum / CLK_FREQ) % 2);
  endfunction

  always @(posedge clk) begin
    if (reset_n !== 1'b1) begin
      for (int i = 0; i < 4; i++) m_mem[i] = 0;
      m_run = 0; m_slot = 0; m_dwell = 0; m_sum = 0; m_base = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start && !stop) begin
          m_run = 1; m_slot = 0; m_dwell = 0; m_sum = 0; m_base = 0;
        end
      end else if (stop) begin
        m_run = 0;
      end else if (m_dwell == DWELL - 1) begin
        m_base  = m_level();
        m_sum   = 0;
        m_dwell = 0;
        if (m_slot < 3) m_slot++;
        else begin
`ifdef FREQ_SYNTH_LOOP_EN
          m_slot = 0;
`else
          m_run  = 0;
          m_done = 1;
`endif
        end
      end else begin
        m_dwell++;
        m_sum += 2 * m_mem[m_slot];
      end
      // memory is written after this cycle's frequency was used
      if (we) m_mem[addr_w] = (longint'(data_w) > HALF) ? HALF : longint'(data_w);
    end
  end

  // ---------------- cycle counter and toggle log ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tog_cyc [$];
  int tog_slot [$];
  logic prev_wave = 1'b0;

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_data_r", data_r, m_mem[addr_r]);
      check("model_waveform", waveform, m_run ? m_level() : 1'b0);
      check("model_busy", busy, m_run);
      check("model_slot", slot, m_slot);
      check("model_done", done, m_done);
      if (busy === 1'b1 && waveform !== prev_wave) begin
        tog_cyc.push_back(cyc);
        tog_slot.push_back(int'(slot));
      end
      prev_wave = waveform;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_mem(input logic [1:0] a, input logic [FREQ_W-1:0] d);
    step();
    we = 1'b1; addr_w = a; data_w = d;
    step();
    we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input longint exp);
    addr_r = a;
    @(negedge clk);
    check(name, data_r, exp);
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_log();
    tog_cyc.delete();
    tog_slot.delete();
  endtask

  // Toggles of slot s after cycle 'after': count, interval count, and
  // how many intervals differ from 'half' clocks.
  task automatic analyze_slot(input int s, input int after, input int half,
                              output int cnt, output int nint, output int nbad);
    int  last;
    bit  have;
    cnt = 0; nint = 0; nbad = 0; have = 0; last = 0;
    foreach (tog_cyc[i]) begin
      if (tog_slot[i] == s && tog_cyc[i] > after) begin
        cnt++;
        if (have) begin
          nint++;
          if (tog_cyc[i] - last != half) nbad++;
        end
        have = 1;
        last = tog_cyc[i];
      end
    end
  endtask

  task automatic wait_slot(input string name, input logic [1:0] s);
    int n;
    n = 0;
    while (slot !== s && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(name, n < 20000, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, cnt, nint, nbad, wcyc;
    bit done_seen;
    logic [FREQ_W-1:0] big;

    // reset
    step();
    chk_en = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    read_check("rst_mem0", 2'd0, 0);
    read_check("rst_mem1", 2'd1, 0);
    read_check("rst_mem2", 2'd2, 0);
    read_check("rst_mem3", 2'd3, 0);
    check("rst_waveform", waveform, 0);
    check("rst_busy", busy, 0);

    // four-slot pass
    write_mem(2'd0, FREQ_W'(2_500_000));
    write_mem(2'd1, FREQ_W'(4_219_409));
    write_mem(2'd2, FREQ_W'(2_000_000));
    write_mem(2'd3, FREQ_W'(769_230));
    read_check("wr_mem1", 2'd1, 4_219_409);
    read_check("wr_mem3", 2'd3, 769_230);
    clear_log();
    pulse_start();
    @(negedge clk);
    n = 0;
    done_seen = 0;
`ifdef FREQ_SYNTH_LOOP_EN
    while (n < 4 * DWELL) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) done_seen = 1;
    end
    check("loop_slot_wrap", slot, 0);
    check("loop_busy", busy, 1);
    check("loop_no_done", done_seen, 0);
    step();
`else
    while (done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", n, 4 * DWELL);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("end_busy", busy, 0);
    check("end_waveform", waveform, 0);
    check("end_slot", slot, 3);
`endif
    analyze_slot(0, 0, 20, cnt, nint, nbad);
    check("s0_toggles", cnt, 199);
    check("s0_half_period_bad", nbad, 0);
    check("s0_intervals", nint, 198);
    analyze_slot(1, 0, 0, cnt, nint, nbad);
    check("s1_toggles", cnt, 337);
    analyze_slot(2, 0, 25, cnt, nint, nbad);
    check("s2_toggles", cnt, 159);
    check("s2_half_period_bad", nbad, 0);
    analyze_slot(3, 0, 0, cnt, nint, nbad);
    check("s3_toggles", cnt, 61);
`ifdef FREQ_SYNTH_LOOP_EN
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge clk);
    check("loop_stop_busy", busy, 0);
`endif

    // saturation, zero-Hz hold, mid-run rewrite, stop
    big = FREQ_W'(200_000_000);
    write_mem(2'd0, big);
    read_check("sat_mem0", 2'd0, 50_000_000);
    write_mem(2'd1, FREQ_W'(0));
    write_mem(2'd2, FREQ_W'(2_000_000));
    clear_log();
    pulse_start();
    wait_slot("reach_slot1", 2'd1);
    repeat (100) @(negedge clk);
    check("zero_hz_hold", waveform, 1);
    wait_slot("reach_slot2", 2'd2);
    repeat (300) @(negedge clk);
    step();
    we = 1'b1; addr_w = 2'd2; data_w = FREQ_W'(5_000_000);
    step();
    we = 1'b0;
    @(negedge clk);
    wcyc = cyc;
    repeat (300) @(negedge clk);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge clk);
    check("stop_busy", busy, 0);
    check("stop_waveform", waveform, 0);
    check("stop_done", done, 0);
    check("stop_slot", slot, 2);
    analyze_slot(0, 0, 1, cnt, nint, nbad);
    check("sat_toggles", cnt, DWELL - 1);
    check("sat_every_clock_bad", nbad, 0);
    analyze_slot(1, 0, 0, cnt, nint, nbad);
    check("zero_hz_toggles", cnt, 0);
    analyze_slot(2, wcyc, 10, cnt, nint, nbad);
    check("rewrite_half_period_bad", nbad, 0);
    check("rewrite_enough_intervals", nint >= 20, 1);

    // start and stop together in idle
    step();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("start_stop_idle", busy, 0);

    // start during run is ignored; start+stop during run stops
    pulse_start();
    repeat (50) step();
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check("restart_ignored_busy", busy, 1);
    repeat (20) step();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("run_start_stop_busy", busy, 0);
    check("run_start_stop_wave", waveform, 0);

    // reset in mid-run
    pulse_start();
    repeat (DWELL + 100) step();
    @(negedge clk);
    check("pre_reset_slot", slot, 1);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_wave", waveform, 0);
    check("mid_reset_slot", slot, 0);
    check("mid_reset_done", done, 0);
    read_check("mid_reset_mem0", 2'd0, 0);
    read_check("mid_reset_mem2", 2'd2, 0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
